// File: rtl/f_pkg.sv
// Shared types and helpers for the candidate driver and its mixed-radix counters.
package f_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN
    } state_t;

    localparam logic [10:0] DBL_EXP_MAX = 11'h7FF;

    // Non-negative, finite doubles only; these then order correctly as unsigned integers.
    function automatic logic dbl_admissible(input logic [63:0] v);
        return !v[63] && (v[62:52] != DBL_EXP_MAX);
    endfunction

    function automatic int awidth_f(input int a);
        return $clog2(a) + 1;
    endfunction

    function automatic int jwidth_f(input int j);
        return $clog2(j) + 1;
    endfunction

endpackage

// File: rtl/mixed_radix_counter.sv
// J-digit base-A counter, digit 0 least significant; wrap flags the increment that rolls over.
module mixed_radix_counter
    import f_pkg::*;
#(
    parameter int J = 14,
    parameter int A = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       inc,
    output logic [J*awidth_f(A)-1:0]   digits,
    output logic                       wrap
);

    localparam int AWIDTH = awidth_f(A);

    logic [J*AWIDTH-1:0] r_digits;
    logic [J*AWIDTH-1:0] w_next;
    logic                w_wrap;

    always_comb begin
        logic c;
        logic [AWIDTH-1:0] d;
        c      = inc;
        w_next = r_digits;
        for (int j = 0; j < J; j++) begin
            d = r_digits[j*AWIDTH +: AWIDTH];
            if (c) begin
                if (d == AWIDTH'(A - 1)) begin
                    w_next[j*AWIDTH +: AWIDTH] = '0;
                end else begin
                    w_next[j*AWIDTH +: AWIDTH] = d + 1'b1;
                    c = 1'b0;
                end
            end
        end
        w_wrap = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= '0;
        end else if (clr) begin
            r_digits <= '0;
        end else if (inc) begin
            r_digits <= w_next;
        end
    end

    assign digits = r_digits;
    assign wrap   = w_wrap;

endmodule

// File: rtl/f_candidate_driver.sv
// Drives every candidate vector into F_case4_flow and tracks the argmax of the returned F values.
module f_candidate_driver
    import f_pkg::*;
#(
    parameter int J = 14,
    parameter int A = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [J*64-1:0]            H_in,
    input  logic [63:0]                y_in,
    input  logic [63:0]                sigma_in,
    output logic                       busy,
    output logic                       done,
    output logic                       best_valid,
    output logic [J*awidth_f(A)-1:0]   best_x,
    output logic [63:0]                best_F,
    output logic [J*64-1:0]            H,
    output logic                       H_tvalid,
    output logic [63:0]                y,
    output logic                       y_tvalid,
    output logic [63:0]                sigma,
    output logic                       sigma_tvalid,
    output logic [awidth_f(A)-1:0]     x,
    output logic                       x_tvalid,
    input  logic [63:0]                F_value,
    input  logic                       F_value_tvalid
);

    localparam int AWIDTH  = awidth_f(A);
    localparam int J_WIDTH = jwidth_f(J);
    localparam int NCAND   = A ** J;
    localparam int C_WIDTH = $clog2(NCAND) + 1;

    state_t              r_state;
    logic [J*64-1:0]     r_H;
    logic [63:0]         r_y;
    logic [63:0]         r_sigma;
    logic                r_load_v;
    logic                r_x_v;
    logic                r_busy;
    logic                r_done;
    logic                r_best_valid;
    logic [J*AWIDTH-1:0] r_best_x;
    logic [63:0]         r_best_F;
    logic [J_WIDTH-1:0]  r_pos;
    logic [C_WIDTH-1:0]  r_res_cnt;

    logic [J*AWIDTH-1:0] w_issue_d;
    logic [J*AWIDTH-1:0] w_res_d;
    logic                w_issue_wrap;
    logic                w_res_wrap;
    logic                w_clr;
    logic                w_issue_last;
    logic                w_res_acc;
    logic                w_upd;
    logic                w_res_done;
    logic [AWIDTH-1:0]   w_x;

    assign w_clr        = (r_state == IDLE) && start;
    assign w_issue_last = (r_state == ISSUE) && (r_pos == J_WIDTH'(J - 1));
    assign w_res_acc    = F_value_tvalid && ((r_state == ISSUE) || (r_state == DRAIN))
                          && (r_res_cnt != C_WIDTH'(NCAND));
    assign w_upd        = w_res_acc && dbl_admissible(F_value)
                          && (!r_best_valid || (F_value > r_best_F));
    // Result counter wraps exactly on the NCAND-th accepted strobe.
    assign w_res_done   = (r_res_cnt == C_WIDTH'(NCAND)) || w_res_wrap;

    mixed_radix_counter #(
        .J (J),
        .A (A)
    ) u_issue_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .inc    (w_issue_last),
        .digits (w_issue_d),
        .wrap   (w_issue_wrap)
    );

    mixed_radix_counter #(
        .J (J),
        .A (A)
    ) u_res_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr),
        .inc    (w_res_acc),
        .digits (w_res_d),
        .wrap   (w_res_wrap)
    );

    always_comb begin
        w_x = '0;
        for (int j = 0; j < J; j++) begin
            if (r_pos == J_WIDTH'(j)) begin
                w_x = w_issue_d[j*AWIDTH +: AWIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_H          <= '0;
            r_y          <= '0;
            r_sigma      <= '0;
            r_load_v     <= 1'b0;
            r_x_v        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_best_valid <= 1'b0;
            r_best_x     <= '0;
            r_best_F     <= '0;
            r_pos        <= '0;
            r_res_cnt    <= '0;
        end else begin
            r_done   <= 1'b0;
            r_load_v <= 1'b0;
            if (w_upd) begin
                r_best_F     <= F_value;
                r_best_x     <= w_res_d;
                r_best_valid <= 1'b1;
            end
            if (w_res_acc) begin
                r_res_cnt <= r_res_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_H          <= H_in;
                        r_y          <= y_in;
                        r_sigma      <= sigma_in;
                        r_best_valid <= 1'b0;
                        r_best_x     <= '0;
                        r_best_F     <= '0;
                        r_res_cnt    <= '0;
                        r_pos        <= '0;
                        r_busy       <= 1'b1;
                        r_load_v     <= 1'b1;
                        r_state      <= LOAD;
                    end
                end
                LOAD: begin
                    r_x_v   <= 1'b1;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    if (r_pos == J_WIDTH'(J - 1)) begin
                        r_pos <= '0;
                        if (w_issue_wrap) begin
                            r_x_v   <= 1'b0;
                            r_state <= DRAIN;
                        end
                    end else begin
                        r_pos <= r_pos + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_res_done) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign best_valid   = r_best_valid;
    assign best_x       = r_best_x;
    assign best_F       = r_best_F;
    assign H            = r_H;
    assign y            = r_y;
    assign sigma        = r_sigma;
    assign H_tvalid     = r_load_v;
    assign y_tvalid     = r_load_v;
    assign sigma_tvalid = r_load_v;
    assign x            = w_x;
    assign x_tvalid     = r_x_v;

endmodule

// File: tb/tb_f_candidate_driver.sv
// Bench for f_candidate_driver: J=2/A=2 and J=2/A=3 instances, each with a 5-cycle stub flow.
module tb_f_candidate_driver;

    localparam int J  = 2;
    localparam int N2 = 4;
    localparam int N3 = 9;

    localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
    localparam logic [63:0] FOUR  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] EIGHT = 64'h4020_0000_0000_0000;
    localparam logic [63:0] HALF  = 64'h3FE0_0000_0000_0000;
    localparam logic [63:0] NEG1  = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] QNAN  = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] PINF  = 64'h7FF0_0000_0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passes = 0;
    int total  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- DUT with A=2 ----------------
    logic         s2_start = 1'b0;
    logic [127:0] s2_H_in = '0;
    logic [63:0]  s2_y_in = '0, s2_sigma_in = '0;
    logic         s2_busy, s2_done, s2_bv, s2_Hv, s2_yv, s2_sv, s2_xv, s2_Fv;
    logic [3:0]   s2_bx;
    logic [63:0]  s2_bF, s2_y, s2_s, s2_F;
    logic [127:0] s2_H;
    logic [1:0]   s2_x;

    f_candidate_driver #(.J(J), .A(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(s2_start), .H_in(s2_H_in), .y_in(s2_y_in),
        .sigma_in(s2_sigma_in), .busy(s2_busy), .done(s2_done), .best_valid(s2_bv),
        .best_x(s2_bx), .best_F(s2_bF), .H(s2_H), .H_tvalid(s2_Hv), .y(s2_y),
        .y_tvalid(s2_yv), .sigma(s2_s), .sigma_tvalid(s2_sv), .x(s2_x), .x_tvalid(s2_xv),
        .F_value(s2_F), .F_value_tvalid(s2_Fv)
    );

    logic [63:0] vals2 [N2];
    int          st2_pos = 0, st2_k = 0;
    logic [4:0]  p2_v = '0;
    int          p2_k [5] = '{default: 0};
    logic        inj2 = 1'b0;
    logic [63:0] inj2_val = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st2_pos <= 0;
            st2_k   <= 0;
            p2_v    <= '0;
        end else begin
            p2_v    <= {p2_v[3:0], (s2_xv && st2_pos == J - 1)};
            p2_k[0] <= st2_k;
            for (int i = 1; i < 5; i++) p2_k[i] <= p2_k[i-1];
            if (s2_Hv) begin
                st2_pos <= 0;
                st2_k   <= 0;
            end else if (s2_xv) begin
                if (st2_pos == J - 1) begin
                    st2_pos <= 0;
                    st2_k   <= st2_k + 1;
                end else begin
                    st2_pos <= st2_pos + 1;
                end
            end
        end
    end
    assign s2_Fv = p2_v[4] | inj2;
    assign s2_F  = inj2 ? inj2_val : vals2[p2_k[4] % N2];

    int           xq2 [$];
    int           hv2 = 0, yv2 = 0, sv2 = 0, dn2 = 0;
    int           c_load2 = -1, c_x0_2 = -1, c_xl2 = -1, c_lastF2 = -1, c_done2 = -1;
    logic [127:0] hcap2 = '0;
    logic [63:0]  ycap2 = '0, scap2 = '0;

    always @(posedge clk) begin
        if (s2_xv) begin
            xq2.push_back(int'(s2_x));
            c_xl2 <= cyc;
            if (c_x0_2 < 0) c_x0_2 <= cyc;
        end
        if (s2_Hv) begin hv2 <= hv2 + 1; c_load2 <= cyc; hcap2 <= s2_H; end
        if (s2_yv) begin yv2 <= yv2 + 1; ycap2 <= s2_y; end
        if (s2_sv) begin sv2 <= sv2 + 1; scap2 <= s2_s; end
        if (s2_Fv) c_lastF2 <= cyc;
        if (s2_done) begin dn2 <= dn2 + 1; c_done2 <= cyc; end
    end

    // ---------------- DUT with A=3 ----------------
    logic         s3_start = 1'b0;
    logic [127:0] s3_H_in = '0;
    logic [63:0]  s3_y_in = '0, s3_sigma_in = '0;
    logic         s3_busy, s3_done, s3_bv, s3_Hv, s3_yv, s3_sv, s3_xv, s3_Fv;
    logic [5:0]   s3_bx;
    logic [63:0]  s3_bF, s3_y, s3_s, s3_F;
    logic [127:0] s3_H;
    logic [2:0]   s3_x;

    f_candidate_driver #(.J(J), .A(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(s3_start), .H_in(s3_H_in), .y_in(s3_y_in),
        .sigma_in(s3_sigma_in), .busy(s3_busy), .done(s3_done), .best_valid(s3_bv),
        .best_x(s3_bx), .best_F(s3_bF), .H(s3_H), .H_tvalid(s3_Hv), .y(s3_y),
        .y_tvalid(s3_yv), .sigma(s3_s), .sigma_tvalid(s3_sv), .x(s3_x), .x_tvalid(s3_xv),
        .F_value(s3_F), .F_value_tvalid(s3_Fv)
    );

    logic [63:0] vals3 [N3];
    int          st3_pos = 0, st3_k = 0;
    logic [4:0]  p3_v = '0;
    int          p3_k [5] = '{default: 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st3_pos <= 0;
            st3_k   <= 0;
            p3_v    <= '0;
        end else begin
            p3_v    <= {p3_v[3:0], (s3_xv && st3_pos == J - 1)};
            p3_k[0] <= st3_k;
            for (int i = 1; i < 5; i++) p3_k[i] <= p3_k[i-1];
            if (s3_Hv) begin
                st3_pos <= 0;
                st3_k   <= 0;
            end else if (s3_xv) begin
                if (st3_pos == J - 1) begin
                    st3_pos <= 0;
                    st3_k   <= st3_k + 1;
                end else begin
                    st3_pos <= st3_pos + 1;
                end
            end
        end
    end
    assign s3_Fv = p3_v[4];
    assign s3_F  = vals3[p3_k[4] % N3];

    int xq3 [$];
    int dn3 = 0;
    always @(posedge clk) begin
        if (s3_xv) xq3.push_back(int'(s3_x));
        if (s3_done) dn3 <= dn3 + 1;
    end

    // ---------------- vector table (A=2) ----------------
    typedef struct packed {
        logic [3:0][63:0] v;
        logic             ev;
        logic [3:0]       ex;
        logic [63:0]      ef;
    } vec_t;

    vec_t tbl [5];
    int   exp_x2 [8] = '{0, 0, 1, 0, 0, 1, 1, 1};

    task automatic setv(input int t, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [63:0] d, input logic ev,
                        input logic [3:0] ex, input logic [63:0] ef);
        tbl[t].v[0] = a;
        tbl[t].v[1] = b;
        tbl[t].v[2] = c;
        tbl[t].v[3] = d;
        tbl[t].ev   = ev;
        tbl[t].ex   = ex;
        tbl[t].ef   = ef;
    endtask

    task automatic clear2();
        xq2.delete();
        hv2 = 0; yv2 = 0; sv2 = 0; dn2 = 0;
        c_load2 = -1; c_x0_2 = -1; c_xl2 = -1; c_lastF2 = -1; c_done2 = -1;
    endtask

    task automatic run2(input logic [127:0] h, input logic [63:0] yy, input logic [63:0] ss,
                        input bit second_start);
        bit seen;
        clear2();
        s2_H_in = h; s2_y_in = yy; s2_sigma_in = ss; s2_start = 1'b1;
        @(negedge clk);
        s2_start = 1'b0;
        if (second_start) begin
            repeat (4) @(negedge clk);
            s2_H_in = ~h; s2_start = 1'b1;
            @(negedge clk);
            s2_start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s2_done) begin seen = 1'b1; break; end
        end
        check("done2_timeout", seen, 1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_stream2(input string name);
        int bad = 0;
        if (xq2.size() != 8) bad = 99;
        else for (int i = 0; i < 8; i++) if (xq2[i] != exp_x2[i]) bad++;
        check({name, "_x_stream"}, bad, 0);
        check({name, "_x_span"}, c_xl2 - c_x0_2 + 1, 8);
    endtask

    initial begin
        logic [127:0] h;
        bit seen;
        int bad;

        repeat (2) @(negedge clk);
        check("rst2_ctrl", {s2_busy, s2_done, s2_bv, s2_bx, s2_Hv, s2_yv, s2_sv, s2_xv}, 0);
        check("rst2_data", {s2_bF, s2_y}, 0);
        check("rst3_ctrl", {s3_busy, s3_done, s3_bv, s3_bx, s3_Hv, s3_xv}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        setv(0, ONE, ONE, ONE, ONE, 1'b1, 4'b0000, ONE);
        setv(1, TWO, EIGHT, EIGHT, FOUR, 1'b1, 4'b0001, EIGHT);
        setv(2, QNAN, NEG1, HALF, HALF, 1'b1, 4'b0100, HALF);
        setv(3, QNAN, QNAN, QNAN, QNAN, 1'b0, 4'b0000, 64'h0);
        setv(4, PINF, ONE, ONE, FOUR, 1'b1, 4'b0101, FOUR);

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < N2; i++) vals2[i] = tbl[t].v[i];
            h = {64'h1111_2222_0000_0000 + 64'(t), 64'h3333_4444_0000_0000 + 64'(t)};
            run2(h, 64'hA000 + 64'(t), 64'hB000 + 64'(t), 1'b0);
            check($sformatf("v%0d_done_count", t), dn2, 1);
            check($sformatf("v%0d_best_valid", t), s2_bv, tbl[t].ev);
            check($sformatf("v%0d_best_x", t), s2_bx, tbl[t].ex);
            check($sformatf("v%0d_best_F", t), s2_bF, tbl[t].ef);
            check_stream2($sformatf("v%0d", t));
            check($sformatf("v%0d_load_counts", t), {hv2[7:0], yv2[7:0], sv2[7:0]}, 24'h010101);
            check($sformatf("v%0d_load_then_x", t), c_x0_2, c_load2 + 1);
            check($sformatf("v%0d_H_cap", t), hcap2, h);
            check($sformatf("v%0d_ys_cap", t), {ycap2, scap2},
                  {64'hA000 + 64'(t), 64'hB000 + 64'(t)});
            check($sformatf("v%0d_done_lat", t), c_done2, c_lastF2 + 1);
            check($sformatf("v%0d_idle_busy", t), s2_busy, 0);
        end

        // Strobe while IDLE must not disturb the held result.
        inj2_val = 64'h7FE0_0000_0000_0000; inj2 = 1'b1;
        @(negedge clk);
        inj2 = 1'b0;
        @(negedge clk);
        check("idle_strobe_F", s2_bF, FOUR);
        check("idle_strobe_x", s2_bx, 4'b0101);

        // Second start during ISSUE is ignored.
        for (int i = 0; i < N2; i++) vals2[i] = ONE;
        h = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        run2(h, 64'h5, 64'h6, 1'b1);
        check("dbl_start_load", hv2, 1);
        check("dbl_start_done", dn2, 1);
        check("dbl_start_H", s2_H, h);
        check_stream2("dbl_start");
        check("dbl_start_best_x", s2_bx, 4'b0000);

        // A=3: 9 candidates, peak at k=7 -> d0=1, d1=2.
        for (int k = 0; k < N3; k++) vals3[k] = (k == 7) ? 64'h4100_0000_0000_0000 : ONE + 64'(k);
        xq3.delete(); dn3 = 0;
        s3_H_in = 128'h77; s3_y_in = 64'h8; s3_sigma_in = 64'h9; s3_start = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s3_done) begin seen = 1'b1; break; end
        end
        check("done3_timeout", seen, 1);
        repeat (6) @(negedge clk);
        bad = 0;
        if (xq3.size() != 2 * N3) bad = 99;
        else for (int k = 0; k < N3; k++)
            for (int j = 0; j < J; j++)
                if (xq3[k*J + j] != (k / (3 ** j)) % 3) bad++;
        check("a3_x_stream", bad, 0);
        check("a3_x_count", xq3.size(), 18);
        check("a3_done_count", dn3, 1);
        check("a3_best_valid", s3_bv, 1);
        check("a3_best_x", s3_bx, 6'b010_001);
        check("a3_best_F", s3_bF, 64'h4100_0000_0000_0000);

        // Reset in the middle of ISSUE, after a first best has been recorded.
        clear2();
        s2_start = 1'b1;
        @(negedge clk);
        s2_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s2_bv) begin seen = 1'b1; break; end
        end
        check("mid_best_seen", seen, 1);
        check("mid_in_issue", s2_xv, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_ctrl", {s2_xv, s2_busy, s2_bv, s2_done}, 0);
        check("mid_rst_best", {s2_bx, s2_bF}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_rst_no_done", dn2, 0);

        for (int i = 0; i < N2; i++) vals2[i] = tbl[1].v[i];
        run2(128'hCAFE, 64'h1, 64'h2, 1'b0);
        check("post_rst_done", dn2, 1);
        check("post_rst_best_x", s2_bx, 4'b0001);
        check("post_rst_best_F", s2_bF, EIGHT);
        check_stream2("post_rst");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
